// File: rtl/subtractor_brentkung_pipe_if.sv
// Valid/ready operand and result bundle for subtractor_brentkung_pipe.
// Carries the optional bin signal when SUB_BORROW_IN_EN is defined.
interface subtractor_brentkung_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SUB_BORROW_IN_EN
    logic             bin;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output in_valid,
`ifdef SUB_BORROW_IN_EN
        output bin,
`endif
        output a, b, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid,
`ifdef SUB_BORROW_IN_EN
        input  bin,
`endif
        input  a, b, out_ready,
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/subtractor_brentkung_pipe.sv
// Two-stage Brent-Kung subtractor (a + ~b + cin): up-sweep registered in S1,
// down-sweep and sum registered in S2. SUB_BORROW_IN_EN adds a borrow-in (bin).
module subtractor_brentkung_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    subtractor_brentkung_pipe_if.slave bus
);

    localparam int unsigned IW = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
    } gp_t;

    // In-place up-sweep: bit i ends up holding the group ending at i whose span
    // is the largest power of two dividing i+1.
    function automatic gp_t up_sweep(input gp_t x);
        gp_t r;
        r = x;
        for (int unsigned d = 1; d < WIDTH; d = d * 2) begin
            for (int unsigned i = 2 * d - 1; i < WIDTH; i = i + 2 * d) begin
                r.g[IW'(i)] = r.g[IW'(i)] | (r.p[IW'(i)] & r.g[IW'(i - d)]);
                r.p[IW'(i)] = r.p[IW'(i)] & r.p[IW'(i - d)];
            end
        end
        return r;
    endfunction

    // Down-sweep fills in the prefixes the up-sweep left as partial groups.
    function automatic logic [WIDTH-1:0] down_sweep(input gp_t x);
        gp_t r;
        r = x;
        for (int unsigned d = WIDTH / 4; d >= 1; d = d / 2) begin
            for (int unsigned i = 3 * d - 1; i < WIDTH; i = i + 2 * d) begin
                r.g[IW'(i)] = r.g[IW'(i)] | (r.p[IW'(i)] & r.g[IW'(i - d)]);
                r.p[IW'(i)] = r.p[IW'(i)] & r.p[IW'(i - d)];
            end
        end
        return r.g;
    endfunction

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;
    logic             accept;
    logic             cin;
    gp_t              gp_in;
    gp_t              s1_gp;
    logic [WIDTH-1:0] s1_p;
    logic             s1_cin;
    logic [WIDTH-1:0] prefix_g;
    logic [WIDTH-1:0] diff_d;
    logic             bout_d;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

`ifdef SUB_BORROW_IN_EN
    assign cin = ~bus.bin;
`else
    assign cin = 1'b1;
`endif

    always_comb begin
        s2_adv = !s2_valid || bus.out_ready;
        s1_adv = !s1_valid || s2_adv;
        accept = bus.in_valid && s1_adv;
    end

    // Carry-in is merged into bit 0's generate, so prefix G[i:0] is the carry
    // into bit i+1; raw p is kept separately for the sum.
    always_comb begin
        gp_in.p    = bus.a ^ ~bus.b;
        gp_in.g    = bus.a & ~bus.b;
        gp_in.g[0] = gp_in.g[0] | (gp_in.p[0] & cin);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_gp  <= up_sweep(gp_in);
            s1_p   <= gp_in.p;
            s1_cin <= cin;
        end
    end

    always_comb begin
        prefix_g = down_sweep(s1_gp);
        diff_d   = s1_p ^ {prefix_g[WIDTH-2:0], s1_cin};
        bout_d   = ~prefix_g[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= accept;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                // Bubbles leave the output regs untouched so unloaded S1 data never reaches them.
                if (s1_valid) begin
                    diff_q <= diff_d;
                    bout_q <= bout_d;
                end
            end
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;

endmodule

// File: tb/tb_subtractor_brentkung_pipe.sv
// Randomized bench for subtractor_brentkung_pipe against an arithmetic queue model.
// Build with SUB_BORROW_IN_EN defined to exercise the borrow-in variant.
module tb_subtractor_brentkung_pipe;

    localparam int unsigned W = 32;

    logic clk;
    logic rst_n;

    subtractor_brentkung_pipe_if #(.WIDTH(W)) bus ();

    subtractor_brentkung_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W:0] res;
        int         acc;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         passes = 0;
    int         cyc = 0;
    int         n_acc = 0;
    int         n_out = 0;
    logic       last_acc = 1'b0;
    logic       hold_prev = 1'b0;
    logic [W:0] held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got === expv) passes++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, expv, cyc);
    endtask

    function automatic logic [W-1:0] rnd();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Reference monitor: occupancy and output order follow from the queue of accepted items.
    always @(negedge clk) begin
        exp_t e;
        logic exp_ov;
        last_acc = 1'b0;
        if (!rst_n) begin
            hold_prev = 1'b0;
            q.delete();
        end else begin
            cyc++;
            exp_ov = (q.size() >= 2) || (q.size() == 1 && (cyc - q[0].acc) >= 2);
            chk("out_valid", bus.out_valid, exp_ov);
            chk("in_ready", bus.in_ready, bus.out_ready || q.size() < 2);
            if (hold_prev) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", {bus.bout, bus.diff}, held);
            end
            if (!bus.out_valid) chk("x_on_output", $isunknown({bus.bout, bus.diff}), 0);
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("result", {bus.bout, bus.diff}, e.res);
                n_out++;
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            held      = {bus.bout, bus.diff};
            if (bus.in_valid && bus.in_ready) begin
                e.res = {1'b0, bus.a} - {1'b0, bus.b};
`ifdef SUB_BORROW_IN_EN
                e.res = e.res - {{W{1'b0}}, bus.bin};
`endif
                e.acc = cyc;
                q.push_back(e);
                last_acc = 1'b1;
                n_acc++;
            end
        end
    end

    task automatic step(input logic v, input logic r);
        @(posedge clk);
        #1;
        if (last_acc || !bus.in_valid) begin
            bus.a = rnd();
            bus.b = rnd();
`ifdef SUB_BORROW_IN_EN
            bus.bin = 1'($urandom_range(0, 1));
`endif
        end
        bus.in_valid  = v;
        bus.out_ready = r;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic directed(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv,
                            input logic [W-1:0] exp_diff, input logic exp_bout);
        int n;
        @(posedge clk);
        #1;
        bus.a = av;
        bus.b = bv;
`ifdef SUB_BORROW_IN_EN
        bus.bin = binv;
`else
        if (binv) $display("note: bin ignored in this build");
`endif
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n = i;
            if (bus.out_valid) break;
            n = 9;
        end
        chk("latency", n, 2);
        chk("lit_diff", bus.diff, exp_diff);
        chk("lit_bout", bus.bout, exp_bout);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int o0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
`ifdef SUB_BORROW_IN_EN
        bus.bin       = 1'b0;
`endif
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_diff", bus.diff, 0);
        chk("rst_bout", bus.bout, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        directed(32'h0000_0010, 32'h0000_0003, 1'b0, 32'h0000_000D, 1'b0);
        directed(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1);
        directed(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b0);
        directed(32'h0000_0003, 32'h0000_0010, 1'b0, 32'hFFFF_FFF3, 1'b1);
`ifdef SUB_BORROW_IN_EN
        directed(32'd5, 32'd5, 1'b1, 32'hFFFF_FFFF, 1'b1);
        directed(32'd7, 32'd2, 1'b1, 32'd4, 1'b0);
`endif
        drain();

        a0 = n_acc;
        o0 = n_out;
        for (int i = 0; i < 1000; i++) step(1'b1, 1'b1);
        @(negedge clk);
        #1;
        chk("stream_accepts", n_acc - a0, 1000);
        chk("stream_outputs", n_out - o0, 998);
        drain();

        a0 = n_acc;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("bp_accepts", n_acc - a0, 2);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_held_items", q.size(), 2);
        drain();

        for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        drain();

        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        @(posedge clk);
        #3;
        bus.in_valid = 1'b0;
        chk("pre_reset_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_diff", bus.diff, 0);
        chk("async_rst_bout", bus.bout, 0);
        chk("async_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        o0 = n_out;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        chk("no_stale_output", n_out - o0, 0);

        directed(32'h1234_5678, 32'h0000_0678, 1'b0, 32'h1234_5000, 1'b0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
